// File: rtl/uart_tx_burst.sv
// uart_tx_burst
//   Multi-byte UART transmitter for the SoC debug/print path. Payload words
//   (NBYTES bytes each) are accepted over a valid/ready handshake into a small
//   FIFO. Each word is sent as 8N1 frames: byte NBYTES-1 first, down to byte 0,
//   then EOL_BYTE when EOL_EN is set. Each byte goes LSB first. Consecutive
//   bytes and consecutive words are sent with no idle gap on the line.
//
//   Optional feature macro: UART_TX_PARITY_EN
//     When defined, an even-parity bit is sent after the data bits
//     (11-bit frames). When undefined, frames are 10 bits and no parity
//     logic is built.
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   i_valid  in   payload word present
//   o_ready  out  FIFO has room; a word transfers when i_valid & o_ready
//   i_data   in   payload word, byte k = i_data[8k+7:8k]
//   o_tx     out  serial line, idles high
//   o_busy   out  a word is stored or the line is still carrying a frame
//   o_level  out  number of words stored in the FIFO
module uart_tx_burst #(
  parameter int         CLK_DIV    = 434,
  parameter int         NBYTES     = 8,
  parameter int         FIFO_DEPTH = 4,
  parameter int         EOL_EN     = 1,
  parameter logic [7:0] EOL_BYTE   = 8'h0A
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [NBYTES*8-1:0]           i_data,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);

  localparam int W      = NBYTES * 8;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int NB_TOT = NBYTES + ((EOL_EN != 0) ? 1 : 0);
  localparam int IDX_W  = $clog2(NB_TOT + 1);
  localparam int BAUD_W = $clog2(CLK_DIV);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t             state_q, state_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [IDX_W-1:0]   byte_idx_q, byte_idx_d;
  logic [W-1:0]       word_q, word_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic               busy_tail_q, busy_tail_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [W-1:0]       mem_q [FIFO_DEPTH];

  logic               push;
  logic               pop;
  logic               bit_done;
  logic [W-1:0]       head;
  logic [W-1:0]       word_shl;
  logic [IDX_W-1:0]   next_idx;

  assign o_ready  = (level_q < LVL_W'(FIFO_DEPTH));
  assign push     = i_valid & o_ready;
  assign head     = mem_q[rd_ptr_q];
  assign bit_done = (baud_q == BAUD_W'(CLK_DIV - 1));
  assign word_shl = word_q << 8;
  assign next_idx = byte_idx_q + 1'b1;

  // The line output is registered, so the line lags the state by one cycle.
  // busy_tail keeps o_busy high through that final cycle of the last stop bit.
  assign o_tx    = tx_q;
  assign o_level = level_q;
  assign o_busy  = (state_q != S_IDLE) | (level_q != '0) | busy_tail_q;

  // FIFO bookkeeping; the serialiser is the only consumer.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= i_data;
  end

  // Frame sequencer. The baud counter wraps exactly when a bit ends, which is
  // also the only time the state changes, so every bit lasts CLK_DIV cycles.
  always_comb begin
    state_d    = state_q;
    baud_d     = '0;
    bit_d      = bit_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    shift_d    = shift_q;
    pop        = 1'b0;
    if (state_q != S_IDLE && !bit_done) baud_d = baud_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (level_q != '0) begin
          pop        = 1'b1;
          word_d     = head;
          shift_d    = head[W-1 -: 8];
          byte_idx_d = '0;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (bit_done) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_done) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_done) begin
          if (byte_idx_q != IDX_W'(NB_TOT - 1)) begin
            // Payload bytes come from the top of the shifted word; the
            // index reaching NBYTES means the terminator is next.
            byte_idx_d = next_idx;
            word_d     = word_shl;
            shift_d    = (next_idx == IDX_W'(NBYTES)) ? EOL_BYTE : word_shl[W-1 -: 8];
            state_d    = S_START;
          end else if (level_q != '0) begin
            pop        = 1'b1;
            word_d     = head;
            shift_d    = head[W-1 -: 8];
            byte_idx_d = '0;
            state_d    = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;

  // Even parity accumulated as the data bits go out.
  always_comb begin
    par_d = par_q;
    if (state_q == S_START) par_d = 1'b0;
    else if (state_q == S_DATA && bit_done) par_d = par_q ^ shift_q[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= par_d;
  end
`endif

  always_comb begin
    tx_d        = 1'b1;
    busy_tail_d = (state_q != S_IDLE);
    case (state_q)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = par_q;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      byte_idx_q  <= '0;
      word_q      <= '0;
      shift_q     <= '0;
      tx_q        <= 1'b1;
      busy_tail_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      byte_idx_q  <= byte_idx_d;
      word_q      <= word_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      busy_tail_q <= busy_tail_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
    end
  end

endmodule
